// File: rtl/gray_count_tracker_pkg.sv
// Shared definitions for Gray-code receivers: tracker FSM states,
// step classification and a width-agnostic Gray-to-binary conversion.
package gray_count_tracker_pkg;

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        TRACK    = 2'd1,
        FAULT    = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        STEP_HOLD = 2'd0,
        STEP_UP   = 2'd1,
        STEP_DOWN = 2'd2,
        STEP_BAD  = 2'd3
    } step_t;

    localparam int GRAY_FN_W = 32;

    // Zero-extended inputs decode correctly at any width up to GRAY_FN_W,
    // because the leading zeros leave the prefix-XOR chain untouched.
    function automatic logic [GRAY_FN_W-1:0] gray_to_bin(input logic [GRAY_FN_W-1:0] g);
        logic [GRAY_FN_W-1:0] b;
        b[GRAY_FN_W-1] = g[GRAY_FN_W-1];
        for (int i = GRAY_FN_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/gray_count_tracker_gray2bin.sv
// Combinational reflected-Gray to binary decoder of parameterised width.
module gray2bin
    import gray_count_tracker_pkg::*;
#(
    parameter int W = 3
) (
    input  logic [W-1:0] gray,
    output logic [W-1:0] bin
);

    assign bin = W'(gray_to_bin(GRAY_FN_W'(gray)));

endmodule

// File: rtl/gray_count_tracker.sv
// Tracks a Gray up/down count stream: decodes each sample, classifies the
// step against the previous sample, keeps a wrapping position and latches FAULT.
module gray_count_tracker
    import gray_count_tracker_pkg::*;
#(
    parameter int W         = 3,
    parameter int POS_W     = 8,
    parameter int ERR_LIMIT = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [W-1:0]     gray_in,
    input  logic             clear,
    output logic [W-1:0]     bin_out,
    output logic             step,
    output logic             mode,
    output logic             err,
    output logic [POS_W-1:0] position,
    output logic             locked,
    output logic             fault
);

    state_t           state_q, state_d;
    logic [W-1:0]     prev_q, prev_d;
    logic [3:0]       err_cnt_q, err_cnt_d;
    logic [W-1:0]     bin_d;
    logic             step_d, mode_d, err_d;
    logic [POS_W-1:0] pos_d;

    logic [W-1:0]     b_new;
    logic [W-1:0]     diff;
    step_t            kind;

    gray2bin #(.W(W)) u_gray2bin (
        .gray (gray_in),
        .bin  (b_new)
    );

    // Modular distance decides direction; this also makes 7->0 an up-step.
    assign diff = b_new - prev_q;

    always_comb begin
        kind = STEP_BAD;
        if (diff == '0)
            kind = STEP_HOLD;
        else if (diff == W'(1))
            kind = STEP_UP;
        else if (diff == '1)
            kind = STEP_DOWN;
    end

    always_comb begin
        state_d   = state_q;
        prev_d    = prev_q;
        err_cnt_d = err_cnt_q;
        bin_d     = bin_out;
        step_d    = 1'b0;
        err_d     = 1'b0;
        mode_d    = mode;
        pos_d     = position;

        case (state_q)
            UNLOCKED: begin
                if (in_valid) begin
                    prev_d    = b_new;
                    bin_d     = b_new;
                    err_cnt_d = '0;
                    state_d   = TRACK;
                end
            end

            TRACK: begin
                if (in_valid) begin
                    // Illegal samples still resync prev so one glitch costs one error.
                    prev_d = b_new;
                    bin_d  = b_new;
                    case (kind)
                        STEP_HOLD: err_cnt_d = '0;
                        STEP_UP: begin
                            step_d    = 1'b1;
                            mode_d    = 1'b1;
                            pos_d     = position + POS_W'(1);
                            err_cnt_d = '0;
                        end
                        STEP_DOWN: begin
                            step_d    = 1'b1;
                            mode_d    = 1'b0;
                            pos_d     = position - POS_W'(1);
                            err_cnt_d = '0;
                        end
                        default: begin
                            err_d     = 1'b1;
                            err_cnt_d = err_cnt_q + 4'd1;
                            if (err_cnt_d == 4'(ERR_LIMIT))
                                state_d = FAULT;
                        end
                    endcase
                end
            end

            FAULT: begin
                if (clear) begin
                    state_d   = UNLOCKED;
                    err_cnt_d = '0;
                end
            end

            default: state_d = UNLOCKED;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= UNLOCKED;
            prev_q    <= '0;
            err_cnt_q <= '0;
            bin_out   <= '0;
            step      <= 1'b0;
            mode      <= 1'b1;
            err       <= 1'b0;
            position  <= '0;
        end else begin
            state_q   <= state_d;
            prev_q    <= prev_d;
            err_cnt_q <= err_cnt_d;
            bin_out   <= bin_d;
            step      <= step_d;
            mode      <= mode_d;
            err       <= err_d;
            position  <= pos_d;
        end
    end

    assign locked = (state_q == TRACK);
    assign fault  = (state_q == FAULT);

endmodule

// File: tb/tb_gray_count_tracker.sv
// Directed table-driven bench for gray_count_tracker plus a reset-mid-stream sequence.
module tb_gray_count_tracker;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic [2:0] gray_in;
    logic       clear;
    logic [2:0] bin_out;
    logic       step;
    logic       mode;
    logic       err;
    logic [7:0] position;
    logic       locked;
    logic       fault;

    int total = 0;
    int bad   = 0;

    gray_count_tracker #(.W(3), .POS_W(8), .ERR_LIMIT(3)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .gray_in  (gray_in),
        .clear    (clear),
        .bin_out  (bin_out),
        .step     (step),
        .mode     (mode),
        .err      (err),
        .position (position),
        .locked   (locked),
        .fault    (fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       vld;
        logic       clr;
        logic [2:0] g;
        logic [2:0] bin;
        logic       stp;
        logic       md;
        logic       er;
        logic [7:0] pos;
        logic       lk;
        logic       flt;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic r, input logic v, input logic c, input logic [2:0] g,
                                input logic [2:0] b, input logic s, input logic m, input logic e,
                                input logic [7:0] p, input logic l, input logic f);
        vec_t x;
        x.rst = r; x.vld = v; x.clr = c; x.g = g;
        x.bin = b; x.stp = s; x.md = m; x.er = e; x.pos = p; x.lk = l; x.flt = f;
        return x;
    endfunction

    // Inputs change on the falling edge; outputs are sampled 1 ns after the rising edge.
    task automatic drive(input logic r, input logic v, input logic c, input logic [2:0] g);
        @(negedge clk);
        reset = r; in_valid = v; clear = c; gray_in = g;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [2:0] b, input logic s, input logic m,
                         input logic e, input logic [7:0] p, input logic l, input logic f);
        total++;
        if ({bin_out, step, mode, err, position, locked, fault} !== {b, s, m, e, p, l, f}) begin
            bad++;
            $display("FAIL %s: got bin=%0d step=%b mode=%b err=%b pos=%0d locked=%b fault=%b, want bin=%0d step=%b mode=%b err=%b pos=%0d locked=%b fault=%b",
                     name, bin_out, step, mode, err, position, locked, fault, b, s, m, e, p, l, f);
        end
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; clear = 1'b0; gray_in = 3'b000;

        // full up-count cycle from reset
        tbl.push_back(mk(1,0,0,3'b000, 0,0,1,0,  0,0,0));
        tbl.push_back(mk(0,1,0,3'b000, 0,0,1,0,  0,1,0));
        tbl.push_back(mk(0,1,0,3'b001, 1,1,1,0,  1,1,0));
        tbl.push_back(mk(0,1,0,3'b011, 2,1,1,0,  2,1,0));
        tbl.push_back(mk(0,1,0,3'b010, 3,1,1,0,  3,1,0));
        tbl.push_back(mk(0,1,0,3'b110, 4,1,1,0,  4,1,0));
        tbl.push_back(mk(0,1,0,3'b111, 5,1,1,0,  5,1,0));
        tbl.push_back(mk(0,1,0,3'b101, 6,1,1,0,  6,1,0));
        tbl.push_back(mk(0,1,0,3'b100, 7,1,1,0,  7,1,0));
        tbl.push_back(mk(0,1,0,3'b000, 0,1,1,0,  8,1,0));
        tbl.push_back(mk(0,0,0,3'b011, 0,0,1,0,  8,1,0));
        // down steps across 0 -> 7 with position wrapping below zero, then back up through 255 -> 0
        tbl.push_back(mk(1,0,0,3'b000, 0,0,1,0,  0,0,0));
        tbl.push_back(mk(0,1,0,3'b000, 0,0,1,0,  0,1,0));
        tbl.push_back(mk(0,1,0,3'b100, 7,1,0,0,255,1,0));
        tbl.push_back(mk(0,1,0,3'b101, 6,1,0,0,254,1,0));
        tbl.push_back(mk(0,1,0,3'b111, 5,1,0,0,253,1,0));
        tbl.push_back(mk(0,1,0,3'b101, 6,1,1,0,254,1,0));
        tbl.push_back(mk(0,1,0,3'b100, 7,1,1,0,255,1,0));
        tbl.push_back(mk(0,1,0,3'b000, 0,1,1,0,  0,1,0));
        // holds and idle cycles
        tbl.push_back(mk(1,0,0,3'b000, 0,0,1,0,  0,0,0));
        tbl.push_back(mk(0,1,0,3'b001, 1,0,1,0,  0,1,0));
        tbl.push_back(mk(0,1,0,3'b001, 1,0,1,0,  0,1,0));
        tbl.push_back(mk(0,1,0,3'b001, 1,0,1,0,  0,1,0));
        tbl.push_back(mk(0,0,0,3'b110, 1,0,1,0,  0,1,0));
        tbl.push_back(mk(0,0,0,3'b100, 1,0,1,0,  0,1,0));
        tbl.push_back(mk(0,0,0,3'b011, 1,0,1,0,  0,1,0));
        // single illegal jump, then legal step
        tbl.push_back(mk(1,0,0,3'b000, 0,0,1,0,  0,0,0));
        tbl.push_back(mk(0,1,0,3'b000, 0,0,1,0,  0,1,0));
        tbl.push_back(mk(0,1,0,3'b011, 2,0,1,1,  0,1,0));
        tbl.push_back(mk(0,1,0,3'b010, 3,1,1,0,  1,1,0));
        // three consecutive errors -> FAULT, ignored samples, clear, relock
        tbl.push_back(mk(1,0,0,3'b000, 0,0,1,0,  0,0,0));
        tbl.push_back(mk(0,1,0,3'b000, 0,0,1,0,  0,1,0));
        tbl.push_back(mk(0,1,0,3'b011, 2,0,1,1,  0,1,0));
        tbl.push_back(mk(0,1,0,3'b101, 6,0,1,1,  0,1,0));
        tbl.push_back(mk(0,1,0,3'b001, 1,0,1,1,  0,0,1));
        tbl.push_back(mk(0,1,0,3'b011, 1,0,1,0,  0,0,1));
        tbl.push_back(mk(0,1,0,3'b010, 1,0,1,0,  0,0,1));
        tbl.push_back(mk(0,1,1,3'b011, 1,0,1,0,  0,0,0));
        tbl.push_back(mk(0,1,0,3'b000, 0,0,1,0,  0,1,0));
        tbl.push_back(mk(0,1,0,3'b001, 1,1,1,0,  1,1,0));
        // two errors, a legal step clears the count, two more errors stay locked
        tbl.push_back(mk(0,1,0,3'b110, 4,0,1,1,  1,1,0));
        tbl.push_back(mk(0,1,0,3'b100, 7,0,1,1,  1,1,0));
        tbl.push_back(mk(0,1,0,3'b000, 0,1,1,0,  2,1,0));
        tbl.push_back(mk(0,1,0,3'b011, 2,0,1,1,  2,1,0));
        tbl.push_back(mk(0,1,0,3'b111, 5,0,1,1,  2,1,0));
        // clear outside FAULT is ignored; the sample is a normal down step
        tbl.push_back(mk(0,1,1,3'b110, 4,1,0,0,  1,1,0));

        foreach (tbl[i]) begin
            drive(tbl[i].rst, tbl[i].vld, tbl[i].clr, tbl[i].g);
            check($sformatf("vec%0d", i), tbl[i].bin, tbl[i].stp, tbl[i].md, tbl[i].er,
                  tbl[i].pos, tbl[i].lk, tbl[i].flt);
        end

        // reset asserted during a streaming up-count at position 5
        drive(1, 0, 0, 3'b000);
        drive(0, 1, 0, 3'b000);
        drive(0, 1, 0, 3'b001);
        drive(0, 1, 0, 3'b011);
        drive(0, 1, 0, 3'b010);
        drive(0, 1, 0, 3'b110);
        drive(0, 1, 0, 3'b111);
        check("stream_pos5", 5, 1, 1, 0, 5, 1, 0);
        drive(1, 1, 0, 3'b101);
        check("reset_midstream", 0, 0, 1, 0, 0, 0, 0);
        drive(0, 1, 0, 3'b011);
        check("relock_after_reset", 2, 0, 1, 0, 0, 1, 0);
        drive(0, 0, 0, 3'b000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
